pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces per-field hand-instantiated flops with one payload bus and a valid/ready handshake.
- Adds a hold control, flush, bubble insertion with a programmable NOP payload, and an optional skid entry that cuts the combinational ready path.
- Upstream concatenates its fields into `in_data_i`. Downstream slices `out_data_o`.

Parameters:
- DW, 64, payload width in bits; legal range 1..1024.
- RST_VAL, {DW{1'b0}}, payload value after reset, after flush and for bubbles; encodes the stage's NOP (for example, register write disabled and load/store code NOPE).
- BUBBLE_CLR, 1, when 1 the payload is forced to RST_VAL whenever the stage holds no valid entry; when 0 the payload keeps its last value when emptied.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- hold_n  in  1  0 freezes the stage: no accept, no emit, state unchanged.
- flush_i  in  1  kills all entries held in the stage.
- in_valid_i  in  1  upstream presents a payload.
- in_ready_o  out  1  stage can accept a payload this cycle.
- in_data_i  in  DW  upstream payload.
- out_valid_o  out  1  stage presents a payload downstream.
- out_ready_i  in  1  downstream accepts the payload this cycle.
- out_data_o  out  DW  payload to downstream.
- bubble_o  out  1  1 for one cycle after the stage emptied because of drain or flush (the stage emitted with no refill).

Behaviour:
- Reset: `rst`=1 at an edge gives `out_valid_o`=0, `out_data_o`=RST_VAL, `bubble_o`=0, and empties any skid entry. Reset overrides `flush_i` and `hold_n`.
- Transfer definitions:
  - Input transfer (acc) = `in_valid_i` & `in_ready_o` & `hold_n`.
  - Output transfer (emit) = `out_valid_o` & `out_ready_i` & `hold_n`.
- Base mode (no skid):
  - Single entry.
  - `in_ready_o` = `hold_n` & (!`out_valid_o` | `out_ready_i`), combinational.
  - acc: next `out_valid_o`=1 and `out_data_o`=`in_data_i`. Latency is 1 cycle, and a full-throughput handoff occurs when acc and emit happen in the same cycle.
  - emit without acc: `out_valid_o`→0. The payload goes to RST_VAL if BUBBLE_CLR=1; otherwise it is unchanged.
- Hold:
  - `hold_n`=0: every register keeps its value, and `in_ready_o`=0.
  - `out_valid_o` keeps its level, but downstream must not count the cycle as a transfer.
- Flush:
  - `flush_i`=1 (and `rst`=0): next `out_valid_o`=0, payload=RST_VAL, skid entry emptied.
  - Flush wins over a simultaneous acc and emit; the incoming payload is discarded.
  - Flush acts even when `hold_n`=0.
- `bubble_o`:
  - Registered, and 1 in the cycle after a flush that killed a valid entry, or after an emit with no acc.
  - 0 otherwise and after reset.
- Payload stability: while `out_valid_o`=1 and no emit, `out_data_o` does not change, regardless of `in_data_i`.
- No combinational path from `in_data_i` to `out_data_o`.

Optional Feature:
- Macro: `PIPE_STAGE_SKID_EN`.
- Defined: the stage adds one skid entry.
  - `in_ready_o` = `hold_n` & !skid_valid; it is driven from a register plus `hold_n` only, with no path from `out_ready_i`.
  - On acc while the main entry is valid and there is no emit, the payload goes into skid.
  - On emit, the skid entry moves into main in the same edge.
  - Capacity is 2, and ordering is strict FIFO.
  - acc and emit with skid empty behave exactly as in base mode.
  - flush or reset empties both entries.
- Undefined: base mode only. No skid storage is synthesised.

Test Plan:
1. Reset, then acc of 0xA5 with `out_ready_i`=1 → `out_valid_o`=1 and `out_data_o`=0xA5 one cycle later. Sustained payloads 1,2,3 on consecutive cycles emerge on consecutive cycles.
2. Backpressure: `out_ready_i`=0 holding 0x11 while upstream offers 0x22 → base mode: `in_ready_o`=0 and output stays 0x11. With `PIPE_STAGE_SKID_EN`: 0x22 is accepted, then `in_ready_o`=0. Raising `out_ready_i` gives 0x11 then 0x22 in order.
3. `hold_n`=0 for 3 cycles with valid 0x33 and `out_ready_i`=1 → output stays 0x33 and valid stays 1. After `hold_n`=1, emit occurs on the first cycle.
4. `flush_i` in the same cycle as acc of 0x44 while 0x55 is held → next cycle: `out_valid_o`=0, `out_data_o`=RST_VAL, `bubble_o`=1. 0x44 never appears.
5. Drain 0x66 with no refill: BUBBLE_CLR=1 gives `out_data_o`=RST_VAL; BUBBLE_CLR=0 gives `out_data_o`=0x66. In both cases `out_valid_o`=0 and `bubble_o`=1 for one cycle.
6. Assert `rst` mid-stream with both entries full and `flush_i`=0 → next cycle: all outputs at reset values, and `in_ready_o`=1 when `hold_n`=1.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle for one pipeline stage boundary.
// master = upstream/downstream environment, slave = the stage register itself.
interface pipe_stage_reg_if #(
    parameter int DW = 64
);
    logic          hold_n;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          bubble_o;

    modport master (
        output hold_n, flush_i, in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, bubble_o
    );

    modport slave (
        input  hold_n, flush_i, in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, bubble_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready, hold, flush and NOP bubbles.
// Define PIPE_STAGE_SKID_EN to add a skid entry that makes in_ready_o purely registered.
module pipe_stage_reg #(
    parameter int            DW         = 64,
    parameter logic [DW-1:0] RST_VAL    = '0,
    parameter bit            BUBBLE_CLR = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    pipe_stage_reg_if.slave bus
);
    logic          main_vld, main_vld_d;
    logic [DW-1:0] main_data, main_data_d;
    logic          bubble, bubble_d;
    logic          rdy;
    logic          acc;
    logic          emit;

`ifdef PIPE_STAGE_SKID_EN
    logic          skid_vld, skid_vld_d;
    logic [DW-1:0] skid_data, skid_data_d;

    // Skid can only be occupied while main is, so ready depends on skid alone.
    assign rdy = bus.hold_n & ~skid_vld;
`else
    assign rdy = bus.hold_n & (~main_vld | bus.out_ready_i);
`endif

    assign acc  = bus.in_valid_i & rdy;
    assign emit = main_vld & bus.out_ready_i & bus.hold_n;

    always_comb begin
        main_vld_d  = main_vld;
        main_data_d = main_data;
        bubble_d    = bubble;
`ifdef PIPE_STAGE_SKID_EN
        skid_vld_d  = skid_vld;
        skid_data_d = skid_data;
`endif
        if (bus.flush_i) begin
            // Flush beats hold, acc and emit; the incoming payload is dropped.
            main_vld_d  = 1'b0;
            main_data_d = RST_VAL;
            bubble_d    = main_vld;
`ifdef PIPE_STAGE_SKID_EN
            skid_vld_d  = 1'b0;
`endif
        end else if (bus.hold_n) begin
            bubble_d = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
            if (emit) begin
                if (skid_vld) begin
                    main_data_d = skid_data;
                    skid_vld_d  = 1'b0;
                end else if (acc) begin
                    main_data_d = bus.in_data_i;
                end else begin
                    main_vld_d = 1'b0;
                    bubble_d   = 1'b1;
                    if (BUBBLE_CLR) main_data_d = RST_VAL;
                end
            end else if (acc) begin
                if (main_vld) begin
                    skid_vld_d  = 1'b1;
                    skid_data_d = bus.in_data_i;
                end else begin
                    main_vld_d  = 1'b1;
                    main_data_d = bus.in_data_i;
                end
            end
`else
            if (acc) begin
                main_vld_d  = 1'b1;
                main_data_d = bus.in_data_i;
            end else if (emit) begin
                main_vld_d = 1'b0;
                bubble_d   = 1'b1;
                if (BUBBLE_CLR) main_data_d = RST_VAL;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld  <= 1'b0;
            main_data <= RST_VAL;
            bubble    <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
            skid_vld  <= 1'b0;
`endif
        end else begin
            main_vld  <= main_vld_d;
            main_data <= main_data_d;
            bubble    <= bubble_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_vld  <= skid_vld_d;
            skid_data <= skid_data_d;
`endif
        end
    end

    assign bus.in_ready_o  = rdy;
    assign bus.out_valid_o = main_vld;
    assign bus.out_data_o  = main_data;
    assign bus.bubble_o    = bubble;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: two stages (BUBBLE_CLR=1 and 0) driven in lockstep against a queue model.
module tb_pipe_stage_reg;
    localparam int          DW  = 16;
    localparam logic [15:0] RV  = 16'h00F0;
`ifdef PIPE_STAGE_SKID_EN
    localparam int          CAP = 2;
`else
    localparam int          CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DW(DW)) b0 ();
    pipe_stage_reg_if #(.DW(DW)) b1 ();

    pipe_stage_reg #(.DW(DW), .RST_VAL(RV), .BUBBLE_CLR(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    pipe_stage_reg #(.DW(DW), .RST_VAL(RV), .BUBBLE_CLR(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int          checks = 0;
    int          passed = 0;
    bit          run    = 0;
    logic [15:0] exp_q[$];
    bit          m_bub  = 0;
    logic [15:0] idle1  = RV;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    task automatic drive(input bit r, input bit h, input bit f, input bit iv,
                         input logic [15:0] d, input bit ordy);
        rst           = r;
        b0.hold_n     = h;    b1.hold_n     = h;
        b0.flush_i    = f;    b1.flush_i    = f;
        b0.in_valid_i = iv;   b1.in_valid_i = iv;
        b0.in_data_i  = d;    b1.in_data_i  = d;
        b0.out_ready_i = ordy; b1.out_ready_i = ordy;
    endtask

    // One cycle: drive, predict, check at negedge, advance model at posedge.
    task automatic step(input bit r, input bit h, input bit f, input bit iv,
                        input logic [15:0] d, input bit ordy);
        int          occ;
        bit          m_rdy, m_acc, m_emit;
        logic [15:0] front;
        drive(r, h, f, iv, d, ordy);
        occ    = exp_q.size();
        front  = (occ > 0) ? exp_q[0] : RV;
        m_rdy  = h && ((occ < CAP) && (CAP == 2 || occ == 0) || (CAP == 1 && ordy));
        m_acc  = iv && m_rdy;
        m_emit = (occ > 0) && ordy && h;
        @(negedge clk);
        chk("in_ready0", {15'd0, b0.in_ready_o}, {15'd0, m_rdy});
        chk("in_ready1", {15'd0, b1.in_ready_o}, {15'd0, m_rdy});
        chk("out_valid0", {15'd0, b0.out_valid_o}, {15'd0, occ > 0});
        chk("out_valid1", {15'd0, b1.out_valid_o}, {15'd0, occ > 0});
        chk("bubble0", {15'd0, b0.bubble_o}, {15'd0, m_bub});
        chk("bubble1", {15'd0, b1.bubble_o}, {15'd0, m_bub});
        if (occ == 0) begin
            chk("idle_data_clr", b0.out_data_o, RV);
            chk("idle_data_keep", b1.out_data_o, idle1);
        end
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            m_bub = 0;
            idle1 = RV;
        end else if (f) begin
            m_bub = occ > 0;
            exp_q.delete();
            idle1 = RV;
        end else if (h) begin
            if (m_acc) exp_q.push_back(d);
            m_bub = m_emit && !m_acc && occ == 1;
            if (m_bub) idle1 = front;
        end
        #1;
    endtask

    // Monitor: the head of the scoreboard must be presented while valid and popped on emit.
    initial begin
        forever begin
            @(negedge clk);
            if (run && b0.out_valid_o && exp_q.size() > 0) begin
                chk("data0", b0.out_data_o, exp_q[0]);
                chk("data1", b1.out_data_o, exp_q[0]);
                if (b0.out_ready_i && b0.hold_n && !b0.flush_i && !rst)
                    void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        drive(1, 1, 0, 0, 16'h0, 1);
        repeat (2) @(posedge clk);
        #1;
        run = 1;
        // reset state then single acc and sustained stream
        step(0, 1, 0, 1, 16'h00A5, 1);
        step(0, 1, 0, 1, 16'h0001, 1);
        step(0, 1, 0, 1, 16'h0002, 1);
        step(0, 1, 0, 1, 16'h0003, 1);
        step(0, 1, 0, 0, 16'h0000, 1);
        step(0, 1, 0, 0, 16'h0000, 1);
        // backpressure
        step(0, 1, 0, 1, 16'h0011, 0);
        repeat (3) step(0, 1, 0, 1, 16'h0022, 0);
        step(0, 1, 0, 0, 16'h0000, 1);
        repeat (3) step(0, 1, 0, 0, 16'h0000, 1);
        // hold with valid payload and ready downstream
        step(0, 1, 0, 1, 16'h0033, 0);
        repeat (3) step(0, 0, 0, 1, 16'h0077, 1);
        step(0, 1, 0, 0, 16'h0000, 1);
        step(0, 1, 0, 0, 16'h0000, 1);
        // flush with simultaneous acc
        step(0, 1, 0, 1, 16'h0055, 0);
        step(0, 1, 1, 1, 16'h0044, 1);
        step(0, 1, 0, 0, 16'h0000, 1);
        step(0, 1, 0, 0, 16'h0000, 1);
        // drain without refill
        step(0, 1, 0, 1, 16'h0066, 1);
        step(0, 1, 0, 0, 16'h0000, 1);
        step(0, 1, 0, 0, 16'h0000, 1);
        step(0, 1, 0, 0, 16'h0000, 1);
        // reset mid-stream with entries held
        step(0, 1, 0, 1, 16'h0081, 0);
        step(0, 1, 0, 1, 16'h0082, 0);
        step(0, 1, 0, 1, 16'h0083, 0);
        step(1, 1, 0, 1, 16'h0084, 0);
        step(0, 1, 0, 0, 16'h0000, 0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 100) == 0, ($urandom % 8) != 0, ($urandom % 25) == 0,
                 ($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0);
        end
        repeat (3) step(0, 1, 0, 0, 16'h0000, 1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
